// File: rtl/cpu_mem_pkg.sv
// Shared widths, FSM encoding and defaults for the CPU-side memory responder.
// Imported by the responder and its storage array.
package cpu_mem_pkg;

  localparam int ADDR_W              = 9;
  localparam int DATA_W              = 32;
  localparam int CNT_W               = 4;
  localparam int WAIT_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/ram_512x32.sv
// Word-addressed storage array: synchronous write, registered read.
// Addresses wrap modulo DEPTH so a smaller array still accepts any 9-bit address.
module ram_512x32
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;

  assign idx = ADDR_W'(32'(addr) % 32'(DEPTH));

  // NOTE: the array has no reset; contents survive clear and no reset fan-out reaches the storage.
  always_ff @(posedge clock) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/memory_responder.sv
// Fixed-latency memory responder: accepts one Read or Write, waits WAIT_CYCLES,
// then acknowledges with a one-cycle mem_ready. Both requests at once is an error.
module memory_responder
  import cpu_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter int DEPTH       = 512
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [ADDR_W-1:0] address,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] MDRdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  op_t               op_q;

  logic              accept;
  logic              illegal;
  logic              enter_ack;
  op_t               access_op;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  // The array is accessed on the edge that enters ACK; with zero wait that is the
  // accept edge itself, so the raw inputs are used there instead of the latches.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    accept    = (state == IDLE) && (Read ^ Write);
    illegal   = (state == IDLE) && Read && Write;
    enter_ack = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (count == CNT_ONE));
    access_op = op_q;
    ram_addr  = addr_q;
    ram_wdata = data_q;
    if (state == IDLE) begin
      access_op = Write ? OP_WRITE : OP_READ;
      ram_addr  = address;
      ram_wdata = MDRdata;
    end
    ram_we = enter_ack && (access_op == OP_WRITE) && !clear;
    ram_re = enter_ack && (access_op == OP_READ);
  end

  ram_512x32 #(.DEPTH(DEPTH)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      count     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      op_q      <= OP_READ;
      Mdatain   <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (illegal) begin
            mem_err <= 1'b1;
          end else if (accept) begin
            addr_q <= address;
            data_q <= MDRdata;
            op_q   <= access_op;
            count  <= WAIT_LOAD;
            state  <= (WAIT_CYCLES == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          count <= count - CNT_ONE;
          if (count == CNT_ONE) state <= ACK;
        end
        ACK: begin
          mem_ready <= 1'b1;
          if (op_q == OP_READ) Mdatain <= ram_rdata;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: two instances (WAIT_CYCLES 2 and 0) driven
// by directed and random requests, checked against an array-based reference model.
module tb_memory_responder;
  import cpu_mem_pkg::*;

  localparam int W_A = 2;
  localparam int W_B = 0;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]        clear_v;
  logic [1:0]        read_v;
  logic [1:0]        write_v;
  logic [1:0][8:0]   address_v;
  logic [1:0][31:0]  wdata_v;
  wire  [1:0][31:0]  rdata_v;
  wire  [1:0]        ready_v;
  wire  [1:0]        err_v;

  memory_responder #(.WAIT_CYCLES(W_A), .DEPTH(512)) u_w2 (
    .clock(clock), .clear(clear_v[0]), .address(address_v[0]), .Read(read_v[0]),
    .Write(write_v[0]), .MDRdata(wdata_v[0]), .Mdatain(rdata_v[0]),
    .mem_ready(ready_v[0]), .mem_err(err_v[0])
  );

  memory_responder #(.WAIT_CYCLES(W_B), .DEPTH(512)) u_w0 (
    .clock(clock), .clear(clear_v[1]), .address(address_v[1]), .Read(read_v[1]),
    .Write(write_v[1]), .MDRdata(wdata_v[1]), .Mdatain(rdata_v[1]),
    .mem_ready(ready_v[1]), .mem_err(err_v[1])
  );

  logic [31:0] model_mem [2][512];
  logic [31:0] model_rd  [2];
  logic        model_err [2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? W_A : W_B;
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int q_front_due(input int d);
    return (d == 0) ? q0[0].due : q1[0].due;
  endfunction

  function automatic exp_t q_pop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic push_exp(input int d, input logic is_read, input logic [31:0] data, input int due);
    exp_t e;
    e.is_read = is_read;
    e.data    = data;
    e.due     = due;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Monitor: every acknowledge must match the oldest expected response and its
  // due cycle; between acknowledges the read data must hold and mem_err must track.
  always @(negedge clock) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (ready_v[d]) begin
        if (q_size(d) == 0) begin
          check("unexpected_ready", 32'(ready_v[d]), 32'd0);
        end else begin
          e = q_pop(d);
          check("ready_cycle", cyc, e.due);
          if (e.is_read) model_rd[d] = e.data;
          check("ack_rdata", rdata_v[d], model_rd[d]);
        end
      end else begin
        if (q_size(d) > 0 && q_front_due(d) <= cyc) begin
          e = q_pop(d);
          check("ready_missing", 32'(ready_v[d]), 32'd1);
        end
        check("rdata_hold", rdata_v[d], model_rd[d]);
      end
      check("err_flag", 32'(err_v[d]), 32'(model_err[d]));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issued just after a rising edge with the DUT idle; a legal request is held
  // until the acknowledge cycle, optionally with the other inputs scrambled.
  task automatic do_req(input int d, input logic rd, input logic wr, input logic [8:0] a,
                        input logic [31:0] wd, input bit scramble);
    int w;
    w = wait_of(d);
    address_v[d] = a;
    wdata_v[d]   = wd;
    read_v[d]    = rd;
    write_v[d]   = wr;
    if (rd ^ wr) begin
      if (rd) begin
        push_exp(d, 1'b1, model_mem[d][a], cyc + w + 2);
      end else begin
        push_exp(d, 1'b0, 32'h0, cyc + w + 2);
        model_mem[d][a] = wd;
      end
      tick();
      if (scramble) begin
        address_v[d] = 9'($urandom);
        wdata_v[d]   = $urandom;
        if (rd) write_v[d] = 1'($urandom);
        else read_v[d] = 1'($urandom);
      end
      repeat (w + 1) @(posedge clock);
      @(negedge clock);
      read_v[d]  = 1'b0;
      write_v[d] = 1'b0;
      tick();
    end else begin
      @(posedge clock);
      if (rd && wr) model_err[d] = 1'b1;
      #1;
      read_v[d]  = 1'b0;
      write_v[d] = 1'b0;
    end
  endtask

  // Read held through the acknowledge: the responder takes it again on the next edge.
  task automatic back_to_back(input int d, input logic [8:0] a);
    int w;
    w = wait_of(d);
    address_v[d] = a;
    read_v[d]    = 1'b1;
    push_exp(d, 1'b1, model_mem[d][a], cyc + w + 2);
    push_exp(d, 1'b1, model_mem[d][a], cyc + 2 * w + 4);
    repeat (2 * w + 4) @(posedge clock);
    @(negedge clock);
    read_v[d] = 1'b0;
    tick();
  endtask

  task automatic do_clear(input int d);
    if (d == 0) q0.delete();
    else q1.delete();
    model_rd[d]  = 32'h0;
    model_err[d] = 1'b0;
    clear_v[d]   = 1'b1;
    #1;
    check("clear_rdata", rdata_v[d], 32'h0);
    check("clear_ready", 32'(ready_v[d]), 32'd0);
    check("clear_err", 32'(err_v[d]), 32'd0);
    @(negedge clock);
    #1;
    clear_v[d] = 1'b0;
    read_v[d]  = 1'b0;
    write_v[d] = 1'b0;
    tick();
  endtask

  logic [8:0] pool [8];
  int         op;
  logic [8:0] ra;

  initial begin
    clear_v   = 2'b11;
    read_v    = '0;
    write_v   = '0;
    address_v = '0;
    wdata_v   = '0;
    for (int d = 0; d < 2; d++) begin
      model_rd[d]  = 32'h0;
      model_err[d] = 1'b0;
    end
    pool = '{9'h000, 9'h001, 9'h012, 9'h014, 9'h0FF, 9'h100, 9'h1FE, 9'h1FF};
    repeat (2) @(posedge clock);
    #1;
    do_clear(0);
    do_clear(1);

    // WAIT_CYCLES = 2: write, read back, hold
    do_req(0, 1'b0, 1'b1, 9'h012, 32'h00000012, 1'b0);
    do_req(0, 1'b1, 1'b0, 9'h012, 32'h0, 1'b0);
    repeat (3) tick();

    // clear during WAIT aborts the pending write
    do_req(0, 1'b0, 1'b1, 9'h014, 32'h11223344, 1'b1);
    address_v[0] = 9'h014;
    wdata_v[0]   = 32'hAAAA5555;
    write_v[0]   = 1'b1;
    tick();
    do_clear(0);
    do_req(0, 1'b1, 1'b0, 9'h014, 32'h0, 1'b1);

    back_to_back(0, 9'h012);

    // both requests at once: rejected, sticky error, memory untouched
    do_req(0, 1'b1, 1'b1, 9'h012, 32'hFFFFFFFF, 1'b0);
    repeat (2) tick();
    do_req(0, 1'b1, 1'b0, 9'h012, 32'h0, 1'b0);
    do_clear(0);

    // WAIT_CYCLES = 0: last word
    do_req(1, 1'b0, 1'b1, 9'h1FF, 32'hDEADBEEF, 1'b0);
    do_req(1, 1'b1, 1'b0, 9'h1FF, 32'h0, 1'b0);
    back_to_back(1, 9'h1FF);

    // random traffic over a small address pool on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) do_req(d, 1'b0, 1'b1, pool[i], $urandom, 1'b1);
      for (int i = 0; i < 30; i++) begin
        op = $urandom_range(9);
        ra = pool[$urandom_range(7)];
        if (op == 0) do_req(d, 1'b1, 1'b1, ra, $urandom, 1'b0);
        else if (op < 5) do_req(d, 1'b0, 1'b1, ra, $urandom, 1'($urandom));
        else do_req(d, 1'b1, 1'b0, ra, $urandom, 1'($urandom));
        repeat ($urandom_range(2)) tick();
      end
    end

    repeat (4) tick();
    check("queue_a_drained", 32'(q0.size()), 32'd0);
    check("queue_b_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait cycles between request accept and acknowledge (legal range 0..15).
REQ-002 The block SHALL have parameter DEPTH, default 512, meaning the number of 32-bit words in the memory array.
REQ-003 The block SHALL have port clock  input  1  system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port clear  input  1  reset; asynchronous and active-high.
REQ-005 The block SHALL have port address  input  9  word address taken from the MAR.
REQ-006 The block SHALL have port Read  input  1  read request, held high by the requester until mem_ready.
REQ-007 The block SHALL have port Write  input  1  write request, held high by the requester until mem_ready.
REQ-008 The block SHALL have port MDRdata  input  32  write data taken from the MDR.
REQ-009 The block SHALL have port Mdatain  output  32  read data driven to the MDR input mux.
REQ-010 The block SHALL have port mem_ready  output  1  one-cycle acknowledge.
REQ-011 The block SHALL have port mem_err  output  1  sticky flag for an illegal request.

Function
REQ-012 FSM states SHALL be IDLE, WAIT and ACK.
REQ-013 IDLE with exactly one of Read/Write high at a rising edge SHALL accept the request: latch address, MDRdata and op, load the counter with WAIT_CYCLES, and enter WAIT (or ACK if WAIT_CYCLES=0).
REQ-014 WAIT SHALL decrement the counter each edge and enter ACK on the edge where the counter is 1.
REQ-015 Latency SHALL be fixed: acceptance at edge E0 gives mem_ready high during exactly the cycle after edge E0+WAIT_CYCLES+1.
REQ-016 On ACK entry, a read SHALL load Mdatain with mem[latched address].
REQ-017 On ACK entry, a write SHALL store the latched data into mem[latched address] and leave Mdatain unchanged.
REQ-018 Mdatain SHALL hold its last read value at all other times.
REQ-019 ACK SHALL always return to IDLE after one cycle; a Read/Write still high in IDLE on the following edge SHALL be accepted as a new request.
REQ-020 Read and Write changing during WAIT/ACK SHALL be ignored; only the latched request SHALL be served.
REQ-021 Read and Write both high in IDLE SHALL be rejected: no memory access, stay in IDLE, mem_ready stays 0, and mem_err is set until clear.
REQ-022 Address SHALL be used modulo DEPTH; the last word (511) SHALL be accessible, with no wrap-around side effects.

Reset
REQ-023 clear high SHALL immediately force state=IDLE, counter=0, Mdatain=32'h0, mem_ready=0 and mem_err=0.
REQ-024 A clear asserted mid-operation SHALL abort the request; a pending write SHALL NOT modify memory.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-026 The FSM state encoding, ADDR_W=9, DATA_W=32 and the WAIT_CYCLES default SHALL live in shared package cpu_mem_pkg.
REQ-027 The storage array SHALL be a single sub-module ram_512x32 (synchronous write, registered read); the FSM, counter and output registers SHALL live in memory_responder.

Verification
REQ-028 Bench SHALL cover: Write addr 9'h012 data 32'h00000012, WAIT_CYCLES=2 -> mem_ready high exactly 3 cycles after accept, one cycle wide.
REQ-029 Bench SHALL cover: Read addr 9'h012 -> Mdatain=32'h00000012 in the mem_ready cycle, held afterwards.
REQ-030 Bench SHALL cover: WAIT_CYCLES=0, Read addr 9'h1FF after write 32'hDEADBEEF -> mem_ready one cycle after accept, Mdatain=32'hDEADBEEF.
REQ-031 Bench SHALL cover: Read and Write both high in IDLE -> no mem_ready, mem_err=1, memory at addr unchanged.
REQ-032 Bench SHALL cover: Write 32'hAAAA5555 to addr 9'h014 with clear pulsed during WAIT -> outputs zero immediately, and a subsequent read of 9'h014 returns the old value.
REQ-033 Bench SHALL cover: Read held high through ACK -> a second request is accepted on the edge after ACK, and the second mem_ready follows after the same latency.
